// File: rtl/edge_fb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : edge_fb_pkg
// Purpose  : Shared types, defaults and derived-constant helpers for the
//            edge-detector frame-buffer write side.
// Contents : fb_state_t FSM encoding, default image/word geometry,
//            helper functions for pixel count, word count, partial-word flag
//            and counter widths.
// Revision : 1.0 - initial release
// ============================================================================
package edge_fb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL      = 2'd1,
    FLUSH     = 2'd2,
    WAIT_SWAP = 2'd3
  } fb_state_t;

  localparam int DEF_IMG_W  = 200;
  localparam int DEF_IMG_H  = 200;
  localparam int DEF_WORD_W = 16;
  localparam int DEF_ADDR_W = 12;

  // Pixels per frame.
  function automatic int fb_frame_pixels(input int img_w, input int img_h);
    return img_w * img_h;
  endfunction

  // RAM words needed to hold one frame.
  function automatic int fb_words(input int n, input int word_w);
    return (n + word_w - 1) / word_w;
  endfunction

  // True when the last word of a frame is only partly filled.
  function automatic bit fb_partial(input int n, input int word_w);
    return (n % word_w) != 0;
  endfunction

  // Width of a counter running 0..limit-1 (at least one bit).
  function automatic int ctr_w(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_pixel_packer.sv
`default_nettype none
// ============================================================================
// Module   : fb_pixel_packer
// Purpose  : Packs 1-bit pixels LSB-first into WORD_W-bit words.
// Ports    : clk, reset      - clock, async active-high reset
//            clear           - drop any partial contents
//            shift_en        - accept pixel this cycle
//            restart         - pixel is bit 0 of a fresh word (old data lost)
//            pixel           - incoming pixel
//            word_full       - this shift completes a word
//            word_next       - word including the incoming pixel
//            flush_word      - current partial word, unused high bits zero
// Revision : 1.0 - initial release
// ============================================================================
module fb_pixel_packer
  import edge_fb_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift_en,
  input  logic              restart,
  input  logic              pixel,
  output logic              word_full,
  output logic [WORD_W-1:0] word_next,
  output logic [WORD_W-1:0] flush_word
);

  localparam int CNT_W = ctr_w(WORD_W);

  logic [WORD_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [WORD_W-1:0] w_base;
  logic [CNT_W-1:0]  w_pos;

  // The accumulator is kept zero above the fill point, so the partial word
  // can be flushed as-is with its unused bits already cleared.
  always_comb begin
    w_base     = restart ? '0 : r_acc;
    w_pos      = restart ? '0 : r_cnt;
    word_next  = w_base | (WORD_W'(pixel) << w_pos);
    word_full  = (w_pos == CNT_W'(WORD_W - 1));
    flush_word = r_acc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (clear) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (shift_en) begin
      if (word_full) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= word_next;
        r_cnt <= w_pos + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/edge_fb_writer.sv
`default_nettype none
// ============================================================================
// Module   : edge_fb_writer
// Purpose  : Write side of the edge-detector frame buffer. Packs the binary
//            pixel stream into RAM words and, with double buffering, swaps
//            display/write banks on a display vsync falling edge.
// Ports    : clk, reset                  - clock, async active-high reset
//            s_valid/s_ready/s_pixel/s_sof - pixel stream handshake
//            wr_en/wr_addr/wr_data/wr_bank - frame-buffer RAM write port
//            disp_vsync (active-low)     - display vertical sync
//            disp_bank                   - bank the display must read
//            frame_done, sof_err         - one-cycle status pulses
// Config   : FB_DOUBLE_BUFFER_EN - two banks with vsync-timed swap; when
//            undefined a single bank is used and disp_vsync is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module edge_fb_writer
  import edge_fb_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int WORD_W = DEF_WORD_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_pixel,
  input  logic              s_sof,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              wr_bank,
  input  logic              disp_vsync,
  output logic              disp_bank,
  output logic              frame_done,
  output logic              sof_err
);

  localparam int N       = fb_frame_pixels(IMG_W, IMG_H);
  localparam int WORDS   = fb_words(N, WORD_W);
  localparam bit PARTIAL = fb_partial(N, WORD_W);
  localparam int X_W     = ctr_w(IMG_W);
  localparam int Y_W     = ctr_w(IMG_H);
  localparam logic [X_W-1:0]    X_LAST    = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

  fb_state_t         r_state, w_state_d;
  logic [X_W-1:0]    r_x, w_x_d, w_cur_x;
  logic [Y_W-1:0]    r_y, w_y_d, w_cur_y;
  logic [ADDR_W-1:0] r_addr, w_addr_d, w_cur_addr;
  logic              r_ready, w_ready_d;
  logic              r_wr_en, w_wr_en_d;
  logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_d;
  logic [WORD_W-1:0] r_wr_data, w_wr_data_d;
  logic              r_frame_done, w_frame_done_d;
  logic              r_sof_err, w_sof_err_d;
  logic              w_pix_beat, w_last, w_clear;
  logic              w_pk_full;
  logic [WORD_W-1:0] w_pk_word, w_pk_flush;

`ifdef FB_DOUBLE_BUFFER_EN
  logic r_disp_bank, w_disp_bank_d;
  logic r_vsync_q;
  logic w_vsync_fall;
  assign w_vsync_fall = r_vsync_q & ~disp_vsync;
`else
  logic unused_vsync;
  assign unused_vsync = disp_vsync;
`endif

  fb_pixel_packer #(.WORD_W(WORD_W)) u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (w_clear),
    .shift_en   (w_pix_beat),
    .restart    (s_sof),
    .pixel      (s_pixel),
    .word_full  (w_pk_full),
    .word_next  (w_pk_word),
    .flush_word (w_pk_flush)
  );

  always_comb begin
    // A beat carrying s_sof is always treated as pixel (0,0), whether it
    // opens a frame from IDLE or aborts one in progress.
    w_pix_beat = s_valid & r_ready &
                 ((r_state == FILL) | ((r_state == IDLE) & s_sof));
    w_cur_x    = s_sof ? '0 : r_x;
    w_cur_y    = s_sof ? '0 : r_y;
    w_cur_addr = s_sof ? '0 : r_addr;
    w_last     = (w_cur_x == X_LAST) && (w_cur_y == Y_LAST);

    w_state_d      = r_state;
    w_x_d          = r_x;
    w_y_d          = r_y;
    w_addr_d       = r_addr;
    w_wr_en_d      = 1'b0;
    w_wr_addr_d    = r_wr_addr;
    w_wr_data_d    = r_wr_data;
    w_frame_done_d = 1'b0;
    w_sof_err_d    = 1'b0;
    w_clear        = 1'b0;
`ifdef FB_DOUBLE_BUFFER_EN
    w_disp_bank_d  = r_disp_bank;
`endif

    case (r_state)
      IDLE, FILL: begin
        if (w_pix_beat) begin
          w_sof_err_d = (r_state == FILL) & s_sof;
          if (w_pk_full) begin
            w_wr_en_d   = 1'b1;
            w_wr_addr_d = w_cur_addr;
            w_wr_data_d = w_pk_word;
          end
          if (w_last) begin
            w_x_d    = '0;
            w_y_d    = '0;
            w_addr_d = '0;
            if (PARTIAL) begin
              w_state_d = FLUSH;
            end else begin
`ifdef FB_DOUBLE_BUFFER_EN
              w_state_d = WAIT_SWAP;
`else
              w_frame_done_d = 1'b1;
              w_state_d      = IDLE;
`endif
            end
          end else begin
            w_state_d = FILL;
            if (w_cur_x == X_LAST) begin
              w_x_d = '0;
              w_y_d = w_cur_y + Y_W'(1);
            end else begin
              w_x_d = w_cur_x + X_W'(1);
              w_y_d = w_cur_y;
            end
            w_addr_d = w_pk_full ? (w_cur_addr + ADDR_W'(1)) : w_cur_addr;
          end
        end
      end

      FLUSH: begin
        w_clear     = 1'b1;
        w_wr_en_d   = 1'b1;
        w_wr_addr_d = LAST_ADDR;
        w_wr_data_d = w_pk_flush;
`ifdef FB_DOUBLE_BUFFER_EN
        w_state_d = WAIT_SWAP;
`else
        w_frame_done_d = 1'b1;
        w_state_d      = IDLE;
`endif
      end

      WAIT_SWAP: begin
`ifdef FB_DOUBLE_BUFFER_EN
        // An edge seen while the final write is still on the bus is
        // skipped; the swap then waits for the following vsync.
        if (w_vsync_fall && !r_wr_en) begin
          w_disp_bank_d  = ~r_disp_bank;
          w_frame_done_d = 1'b1;
          w_state_d      = IDLE;
        end
`else
        w_state_d = IDLE;
`endif
      end

      default: w_state_d = IDLE;
    endcase

    // Ready is also held low in the frame_done cycle so the end of a frame
    // always shows one cycle of s_ready=0.
    w_ready_d = ((w_state_d == IDLE) || (w_state_d == FILL)) && !w_frame_done_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_addr       <= '0;
      r_ready      <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_frame_done <= 1'b0;
      r_sof_err    <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_x          <= w_x_d;
      r_y          <= w_y_d;
      r_addr       <= w_addr_d;
      r_ready      <= w_ready_d;
      r_wr_en      <= w_wr_en_d;
      r_wr_addr    <= w_wr_addr_d;
      r_wr_data    <= w_wr_data_d;
      r_frame_done <= w_frame_done_d;
      r_sof_err    <= w_sof_err_d;
    end
  end

`ifdef FB_DOUBLE_BUFFER_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_disp_bank <= 1'b0;
      r_vsync_q   <= 1'b1;
    end else begin
      r_disp_bank <= w_disp_bank_d;
      r_vsync_q   <= disp_vsync;
    end
  end
  assign disp_bank = r_disp_bank;
  assign wr_bank   = ~r_disp_bank;
`else
  assign disp_bank = 1'b0;
  assign wr_bank   = 1'b0;
`endif

  assign s_ready    = r_ready;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign frame_done = r_frame_done;
  assign sof_err    = r_sof_err;

endmodule
`default_nettype wire

// File: tb/tb_edge_fb_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_fb_writer
// Purpose  : Directed self-checking bench for edge_fb_writer. dut_a uses the
//            default 200x200x16 geometry, dut_b a 5x5 image that needs a
//            FLUSH word. Bank checks follow FB_DOUBLE_BUFFER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_edge_fb_writer;

`ifdef FB_DOUBLE_BUFFER_EN
  localparam logic EXP_WB = 1'b1;
`else
  localparam logic EXP_WB = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // dut_a : default geometry
  logic        a_reset, a_s_valid, a_s_ready, a_s_pixel, a_s_sof;
  logic        a_wr_en, a_wr_bank, a_vsync, a_disp_bank, a_frame_done, a_sof_err;
  logic [11:0] a_wr_addr;
  logic [15:0] a_wr_data;

  // dut_b : 5x5 image
  logic        b_reset, b_s_valid, b_s_ready, b_s_pixel, b_s_sof;
  logic        b_wr_en, b_wr_bank, b_vsync, b_disp_bank, b_frame_done, b_sof_err;
  logic [11:0] b_wr_addr;
  logic [15:0] b_wr_data;

  edge_fb_writer dut_a (
    .clk(clk), .reset(a_reset),
    .s_valid(a_s_valid), .s_ready(a_s_ready), .s_pixel(a_s_pixel), .s_sof(a_s_sof),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_bank(a_wr_bank),
    .disp_vsync(a_vsync), .disp_bank(a_disp_bank),
    .frame_done(a_frame_done), .sof_err(a_sof_err)
  );

  edge_fb_writer #(.IMG_W(5), .IMG_H(5), .WORD_W(16), .ADDR_W(12)) dut_b (
    .clk(clk), .reset(b_reset),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_pixel(b_s_pixel), .s_sof(b_s_sof),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_bank(b_wr_bank),
    .disp_vsync(b_vsync), .disp_bank(b_disp_bank),
    .frame_done(b_frame_done), .sof_err(b_sof_err)
  );

  // Write / pulse monitors, sampled mid-cycle on the falling edge.
  int          a_wr_cnt = 0, a_bad = 0, a_fd_cnt = 0, a_se_cnt = 0, a_full_base = 0;
  bit          a_chk_full = 1'b0;
  logic [11:0] a_last_addr = '0;
  logic [15:0] a_last_data = '0;
  int          b_wr_cnt = 0, b_fd_cnt = 0;
  logic [11:0] b_first_addr = '0;
  logic [15:0] b_first_data = '0;

  always @(negedge clk) begin
    if (a_wr_en) begin
      if (a_chk_full && ((a_wr_addr !== 12'(a_wr_cnt - a_full_base)) || (a_wr_data !== 16'hAAAA)))
        a_bad++;
      a_last_addr = a_wr_addr;
      a_last_data = a_wr_data;
      a_wr_cnt++;
    end
    if (a_frame_done) a_fd_cnt++;
    if (a_sof_err)    a_se_cnt++;
    if (b_wr_en) begin
      if (b_wr_cnt == 0) begin
        b_first_addr = b_wr_addr;
        b_first_data = b_wr_data;
      end
      b_wr_cnt++;
    end
    if (b_frame_done) b_fd_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic pix, input logic sof);
    int guard = 0;
    a_s_valid = 1'b1; a_s_pixel = pix; a_s_sof = sof;
    while (!a_s_ready && guard < 50) begin tick(); guard++; end
    if (!a_s_ready) check("a_send_timeout", 32'(a_s_ready), 32'd1);
    tick();
    a_s_valid = 1'b0; a_s_sof = 1'b0;
  endtask

  task automatic send_b(input logic pix, input logic sof);
    int guard = 0;
    b_s_valid = 1'b1; b_s_pixel = pix; b_s_sof = sof;
    while (!b_s_ready && guard < 50) begin tick(); guard++; end
    if (!b_s_ready) check("b_send_timeout", 32'(b_s_ready), 32'd1);
    tick();
    b_s_valid = 1'b0; b_s_sof = 1'b0;
  endtask

  initial begin
    int base;
    int hi_cnt;
    a_reset = 1'b1; a_s_valid = 1'b0; a_s_pixel = 1'b0; a_s_sof = 1'b0; a_vsync = 1'b1;
    b_reset = 1'b1; b_s_valid = 1'b0; b_s_pixel = 1'b0; b_s_sof = 1'b0; b_vsync = 1'b1;
    repeat (3) tick();

    // ---- reset state ----
    check("rst_s_ready",    32'(a_s_ready),    32'd0);
    check("rst_wr_en",      32'(a_wr_en),      32'd0);
    check("rst_wr_addr",    32'(a_wr_addr),    32'd0);
    check("rst_wr_data",    32'(a_wr_data),    32'd0);
    check("rst_disp_bank",  32'(a_disp_bank),  32'd0);
    check("rst_wr_bank",    32'(a_wr_bank),    32'(EXP_WB));
    check("rst_frame_done", 32'(a_frame_done), 32'd0);
    check("rst_sof_err",    32'(a_sof_err),    32'd0);
    a_reset = 1'b0; b_reset = 1'b0;
    tick();
    check("ready_after_release", 32'(a_s_ready), 32'd1);

    // ---- full default frame, pixel = k mod 2 ----
    a_full_base = a_wr_cnt;
    a_chk_full  = 1'b1;
    for (int k = 0; k < 40000; k++) send_a(k[0], k == 0);
    check("ready_low_after_last", 32'(a_s_ready), 32'd0);
    check("last_word_wr_en",      32'(a_wr_en),   32'd1);
    check("last_word_addr",       32'(a_wr_addr), 32'd2499);
`ifdef FB_DOUBLE_BUFFER_EN
    check("no_done_before_swap", 32'(a_frame_done), 32'd0);
    hi_cnt = 0;
    repeat (100) begin tick(); if (a_s_ready) hi_cnt++; end
    a_chk_full = 1'b0;
    check("full_write_count", 32'(a_wr_cnt - a_full_base), 32'd2500);
    check("full_bad_words",   32'(a_bad),                  32'd0);
    check("wait_ready_high",  32'(hi_cnt),                 32'd0);
    check("wait_no_done",     32'(a_fd_cnt),               32'd0);
    check("wait_disp_bank",   32'(a_disp_bank),            32'd0);
    a_vsync = 1'b0;
    tick();
    check("swap_disp_bank",  32'(a_disp_bank),  32'd1);
    check("swap_wr_bank",    32'(a_wr_bank),    32'd0);
    check("swap_frame_done", 32'(a_frame_done), 32'd1);
    tick();
    check("swap_done_single", 32'(a_frame_done), 32'd0);
    tick();
    check("swap_done_count", 32'(a_fd_cnt), 32'd1);
    a_vsync = 1'b1;
`else
    check("done_with_last_write", 32'(a_frame_done), 32'd1);
    repeat (3) tick();
    a_chk_full = 1'b0;
    check("full_write_count", 32'(a_wr_cnt - a_full_base), 32'd2500);
    check("full_bad_words",   32'(a_bad),                  32'd0);
    check("done_count",       32'(a_fd_cnt),               32'd1);
    check("single_disp_bank", 32'(a_disp_bank),            32'd0);
    check("ready_back_idle",  32'(a_s_ready),              32'd1);
`endif
    tick();

    // ---- beats without s_sof in IDLE are discarded ----
    base = a_wr_cnt;
    hi_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (a_s_ready) hi_cnt++;
      send_a(1'b1, 1'b0);
    end
    tick();
    check("idle_beats_ready", 32'(hi_cnt),          32'd10);
    check("idle_no_writes",   32'(a_wr_cnt - base), 32'd0);

    // ---- s_sof at k=20 aborts the frame ----
    for (int k = 0; k < 20; k++) send_a(1'b1, k == 0);
    check("pre_abort_writes", 32'(a_wr_cnt - base), 32'd1);
    check("pre_abort_addr",   32'(a_last_addr),     32'd0);
    check("pre_abort_data",   32'(a_last_data),     32'hFFFF);
    send_a(1'b1, 1'b1);
    check("sof_err_pulse",    32'(a_sof_err), 32'd1);
    check("abort_no_write",   32'(a_wr_en),   32'd0);
    for (int k = 1; k < 16; k++) send_a((k % 3) == 0, 1'b0);
    check("abort_no_partial", 32'(a_wr_cnt - base), 32'd1);
    check("restart_wr_en",    32'(a_wr_en),         32'd1);
    check("restart_addr",     32'(a_wr_addr),       32'd0);
    check("restart_data",     32'(a_wr_data),       32'h9249);
    check("sof_err_count",    32'(a_se_cnt),        32'd1);

    // ---- reset in FILL at k=100 ----
    for (int k = 16; k < 100; k++) send_a(1'b1, 1'b0);
    check("pre_reset_addr", 32'(a_wr_addr), 32'd5);
    a_reset = 1'b1;
    #1;
    check("mid_rst_s_ready",    32'(a_s_ready),    32'd0);
    check("mid_rst_wr_en",      32'(a_wr_en),      32'd0);
    check("mid_rst_wr_addr",    32'(a_wr_addr),    32'd0);
    check("mid_rst_wr_data",    32'(a_wr_data),    32'd0);
    check("mid_rst_disp_bank",  32'(a_disp_bank),  32'd0);
    check("mid_rst_wr_bank",    32'(a_wr_bank),    32'(EXP_WB));
    check("mid_rst_frame_done", 32'(a_frame_done), 32'd0);
    check("mid_rst_sof_err",    32'(a_sof_err),    32'd0);
    repeat (2) tick();
    a_reset = 1'b0;
    tick();
    check("post_rst_ready", 32'(a_s_ready), 32'd1);
    base = a_wr_cnt;
    for (int i = 0; i < 5; i++) send_a(1'b1, 1'b0);
    for (int k = 0; k < 16; k++) send_a(k < 8, k == 0);
    check("post_rst_prior_writes", 32'(a_wr_cnt - base), 32'd0);
    check("post_rst_wr_en",        32'(a_wr_en),         32'd1);
    check("post_rst_addr",         32'(a_wr_addr),       32'd0);
    check("post_rst_data",         32'(a_wr_data),       32'h00FF);

    // ---- 5x5 frame with FLUSH ----
    for (int k = 0; k < 25; k++) send_b(1'b1, k == 0);
    check("b_ready_low",   32'(b_s_ready),    32'd0);
    check("b_flush_no_wr", 32'(b_wr_en),      32'd0);
    check("b_first_count", 32'(b_wr_cnt),     32'd1);
    check("b_first_addr",  32'(b_first_addr), 32'd0);
    check("b_first_data",  32'(b_first_data), 32'hFFFF);
    tick();
    check("b_flush_wr_en", 32'(b_wr_en),     32'd1);
    check("b_flush_addr",  32'(b_wr_addr),   32'd1);
    check("b_flush_data",  32'(b_wr_data),   32'h01FF);
    check("b_flush_ready", 32'(b_s_ready),   32'd0);
`ifdef FB_DOUBLE_BUFFER_EN
    check("b_flush_no_done", 32'(b_frame_done), 32'd0);
    b_vsync = 1'b0;
    tick();
    check("b_edge_on_write_done", 32'(b_frame_done), 32'd0);
    check("b_edge_on_write_bank", 32'(b_disp_bank),  32'd0);
    b_vsync = 1'b1;
    repeat (2) tick();
    b_vsync = 1'b0;
    tick();
    check("b_swap_done",      32'(b_frame_done), 32'd1);
    check("b_swap_disp_bank", 32'(b_disp_bank),  32'd1);
    check("b_swap_wr_bank",   32'(b_wr_bank),    32'd0);
    tick();
`else
    check("b_flush_done", 32'(b_frame_done), 32'd1);
    tick();
`endif
    check("b_ready_idle", 32'(b_s_ready), 32'd1);
    check("b_done_count", 32'(b_fd_cnt),  32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
